// File: rtl/contadores_multicanal_if.sv
// Request/readout bundle for the multichannel push counters.
// The master drives pushes and requests; the slave returns the registered readout.
interface contadores_multicanal_if #(
  parameter int NCH   = 4,
  parameter int IDXW  = 2,
  parameter int CBITS = 7
);
  logic [NCH-1:0]   push;
  logic             idle;
  logic             req;
  logic [IDXW-1:0]  idx;
  logic             dump_req;
  logic             clr_all;
  logic [CBITS-1:0] counter_out;
  logic [IDXW-1:0]  idx_out;
  logic             valid_out;
  logic             ovf_out;
  logic             busy;

  modport master (
    output push, idle, req, idx, dump_req, clr_all,
    input  counter_out, idx_out, valid_out, ovf_out, busy
  );
  modport slave (
    input  push, idle, req, idx, dump_req, clr_all,
    output counter_out, idx_out, valid_out, ovf_out, busy
  );
endinterface

// File: rtl/contadores_multicanal.sv
// Per-channel push counters (wrap or saturate, sticky overflow) with a registered
// single-channel or streamed readout that only runs while the datapath is idle.
module contadores_canal #(
  parameter int CBITS    = 7,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             clr,
  input  logic             rd_clr,
  output logic [CBITS-1:0] cnt,
  output logic             ovf
);
  localparam logic [CBITS-1:0] MAX = {CBITS{1'b1}};

  logic [CBITS-1:0] cnt_q, cnt_d, base_c;
  logic             ovf_q, ovf_d, base_o;

  always_comb begin
    // a clear-on-read restarts from zero before this edge's push is applied
    base_c = rd_clr ? '0 : cnt_q;
    base_o = rd_clr ? 1'b0 : ovf_q;
    cnt_d  = base_c;
    ovf_d  = base_o;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (push) begin
      if (base_c == MAX) begin
        ovf_d = 1'b1;
        cnt_d = (SATURATE != 0) ? MAX : '0;
      end else begin
        cnt_d = base_c + CBITS'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;
endmodule

module contadores_multicanal #(
  parameter int NCH         = 4,
  parameter int IDXW        = 2,
  parameter int CBITS       = 7,
  parameter int SATURATE    = 0,
  parameter int CLR_ON_READ = 0
) (
  input logic                     clk,
  input logic                     reset,
  contadores_multicanal_if.slave  bus
);
  typedef enum logic {ST_WAIT, ST_DUMP} state_t;

  state_t                      state_q, state_d;
  logic [IDXW-1:0]             ptr_q, ptr_d;
  logic [CBITS-1:0]            counter_out_q, counter_out_d;
  logic [IDXW-1:0]             idx_out_q, idx_out_d;
  logic                        valid_out_q, valid_out_d;
  logic                        ovf_out_q, ovf_out_d;
  logic                        busy_q, busy_d;
  logic                        emit, emit_dump, sel_ok;
  logic [IDXW-1:0]             sel;
  logic [NCH-1:0][CBITS-1:0]   cnt;
  logic [NCH-1:0]              ovf;
  logic [NCH-1:0]              rd_clr;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign rd_clr[i] = (CLR_ON_READ != 0) && emit && (sel == IDXW'(i));
    contadores_canal #(.CBITS(CBITS), .SATURATE(SATURATE)) u_ch (
      .clk    (clk),
      .reset  (reset),
      .push   (bus.push[i]),
      .clr    (bus.clr_all),
      .rd_clr (rd_clr[i]),
      .cnt    (cnt[i]),
      .ovf    (ovf[i])
    );
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    emit      = 1'b0;
    emit_dump = 1'b0;
    sel       = ptr_q;
    case (state_q)
      // busy_q covers the cycle carrying the last dump entry
      ST_WAIT: if (bus.idle && !busy_q) begin
        if (bus.dump_req) begin
          emit      = 1'b1;
          emit_dump = 1'b1;
          sel       = '0;
          ptr_d     = IDXW'(1);
          state_d   = ST_DUMP;
        end else if (bus.req) begin
          emit = 1'b1;
          sel  = bus.idx;
        end
      end
      ST_DUMP: if (!bus.idle) begin
        state_d = ST_WAIT;
      end else begin
        emit      = 1'b1;
        emit_dump = 1'b1;
        ptr_d     = ptr_q + IDXW'(1);
        if (ptr_q == IDXW'(NCH - 1)) state_d = ST_WAIT;
      end
      default: state_d = ST_WAIT;
    endcase

    sel_ok        = int'(sel) < NCH;
    counter_out_d = (emit && sel_ok) ? cnt[sel] : '0;
    ovf_out_d     = emit && sel_ok && ovf[sel];
    idx_out_d     = emit ? sel : '0;
    valid_out_d   = emit;
    busy_d        = emit_dump;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_WAIT;
      ptr_q         <= '0;
      counter_out_q <= '0;
      idx_out_q     <= '0;
      valid_out_q   <= 1'b0;
      ovf_out_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      counter_out_q <= counter_out_d;
      idx_out_q     <= idx_out_d;
      valid_out_q   <= valid_out_d;
      ovf_out_q     <= ovf_out_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.counter_out = counter_out_q;
  assign bus.idx_out     = idx_out_q;
  assign bus.valid_out   = valid_out_q;
  assign bus.ovf_out     = ovf_out_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_contadores_multicanal.sv
// Directed bench: three configurations (wrap, saturate, clear-on-read) share one stimulus;
// expected readouts are queued per instance and popped by a negedge monitor.
module tb_contadores_multicanal;
  localparam int NCH = 4, IDXW = 2, CBITS = 7;

  logic clk = 1'b0, reset = 1'b1;
  logic [NCH-1:0]  push = '0;
  logic            idle = 1'b1, req = 1'b0, dump_req = 1'b0, clr_all = 1'b0;
  logic [IDXW-1:0] idx = '0;
  int n_asr = 0, n_fail = 0;
  int v3[4] = '{3, 0, 7, 1};

  typedef struct { int c; int i; int o; int b; } exp_t;
  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  contadores_multicanal_if #(.NCH(NCH), .IDXW(IDXW), .CBITS(CBITS)) if0 (), if1 (), if2 ();
  assign {if0.push, if0.idle, if0.req, if0.idx, if0.dump_req, if0.clr_all} = {push, idle, req, idx, dump_req, clr_all};
  assign {if1.push, if1.idle, if1.req, if1.idx, if1.dump_req, if1.clr_all} = {push, idle, req, idx, dump_req, clr_all};
  assign {if2.push, if2.idle, if2.req, if2.idx, if2.dump_req, if2.clr_all} = {push, idle, req, idx, dump_req, clr_all};

  contadores_multicanal #(.NCH(NCH), .IDXW(IDXW), .CBITS(CBITS), .SATURATE(0), .CLR_ON_READ(0))
    u_wrap (.clk(clk), .reset(reset), .bus(if0));
  contadores_multicanal #(.NCH(NCH), .IDXW(IDXW), .CBITS(CBITS), .SATURATE(1), .CLR_ON_READ(0))
    u_sat (.clk(clk), .reset(reset), .bus(if1));
  contadores_multicanal #(.NCH(NCH), .IDXW(IDXW), .CBITS(CBITS), .SATURATE(0), .CLR_ON_READ(1))
    u_cor (.clk(clk), .reset(reset), .bus(if2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asr++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic exp_push(input int d, input int c, input int i, input int o, input int b);
    exp_t e;
    e = '{c: c, i: i, o: o, b: b};
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic exp_all(input int c, input int i, input int o, input int b);
    for (int d = 0; d < 3; d++) exp_push(d, c, i, o, b);
  endtask

  task automatic check_dut(input int d, input logic v, input logic [CBITS-1:0] c,
                           input logic [IDXW-1:0] ix, input logic o, input logic b);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (v === 1'b1) begin
      case (d)
        0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
      endcase
      chk($sformatf("dut%0d_expected_entry", d), 32'(have), 32'd1);
      if (have) begin
        chk($sformatf("dut%0d_counter_out", d), 32'(c), 32'(e.c));
        chk($sformatf("dut%0d_idx_out", d), 32'(ix), 32'(e.i));
        chk($sformatf("dut%0d_ovf_out", d), 32'(o), 32'(e.o));
        chk($sformatf("dut%0d_busy", d), 32'(b), 32'(e.b));
      end
    end else begin
      chk($sformatf("dut%0d_valid_idle", d), 32'(v), 32'd0);
      chk($sformatf("dut%0d_zero_when_idle", d), 32'({c, ix, o, b}), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    check_dut(0, if0.valid_out, if0.counter_out, if0.idx_out, if0.ovf_out, if0.busy);
    check_dut(1, if1.valid_out, if1.counter_out, if1.idx_out, if1.ovf_out, if1.busy);
    check_dut(2, if2.valid_out, if2.counter_out, if2.idx_out, if2.ovf_out, if2.busy);
  end

  initial begin
    // reset state
    tick(); tick();
    chk("reset_valid", 32'(if0.valid_out), 32'd0);
    chk("reset_counter_out", 32'(if0.counter_out), 32'd0);
    chk("reset_busy", 32'(if1.busy), 32'd0);
    reset = 1'b0;

    // five pushes on ch2 then a single read
    push = 4'b0100; repeat (5) tick(); push = '0;
    req = 1'b1; idx = 2'd2; exp_all(5, 2, 0, 0); tick(); req = 1'b0;
    repeat (2) tick();

    // 130 pushes on ch1: wrap lands on 2, saturate holds at 127, both flag overflow
    do_reset();
    push = 4'b0010; repeat (130) tick(); push = '0;
    req = 1'b1; idx = 2'd1;
    exp_push(0, 2, 1, 1, 0); exp_push(1, 127, 1, 1, 0); exp_push(2, 2, 1, 1, 0);
    tick();
    idx = 2'd0; exp_all(0, 0, 0, 0); tick(); req = 1'b0;
    repeat (2) tick();

    // dump of {3,0,7,1}; dump_req wins over req, req during dump ignored
    do_reset();
    push = 4'b1101; tick();
    push = 4'b0101; repeat (2) tick();
    push = 4'b0100; repeat (4) tick(); push = '0;
    dump_req = 1'b1; req = 1'b1; idx = 2'd3;
    for (int i = 0; i < NCH; i++) exp_all(v3[i], i, 0, 1);
    tick(); dump_req = 1'b0; idx = 2'd2;
    tick(); req = 1'b0;
    repeat (6) tick();

    // idle drops after the second dump entry: stream aborts, requests refused while not idle
    do_reset();
    push = 4'b0011; repeat (2) tick(); push = '0;
    dump_req = 1'b1; exp_all(2, 0, 0, 1); exp_all(2, 1, 0, 1);
    tick(); dump_req = 1'b0;
    tick(); idle = 1'b0;
    tick(); req = 1'b1; idx = 2'd0;
    repeat (3) tick(); req = 1'b0; idle = 1'b1;
    repeat (3) tick();

    // read with a push on the same edge; clear-on-read leaves only that push
    do_reset();
    push = 4'b0001; repeat (4) tick();
    req = 1'b1; idx = 2'd0; exp_all(4, 0, 0, 0); tick(); push = '0; req = 1'b0;
    tick();
    req = 1'b1; exp_push(0, 5, 0, 0, 0); exp_push(1, 5, 0, 0, 0); exp_push(2, 1, 0, 0, 0);
    tick(); req = 1'b0;
    repeat (2) tick();

    // clr_all beats a same-edge push and drops sticky overflow
    do_reset();
    push = 4'b1000; repeat (128) tick();
    clr_all = 1'b1; tick(); clr_all = 1'b0; push = '0;
    dump_req = 1'b1;
    for (int i = 0; i < NCH; i++) exp_all(0, i, 0, 1);
    tick(); dump_req = 1'b0;
    repeat (5) tick();

    // reset mid-dump: only ch0 is ever observed, outputs drop at once
    push = 4'b1111; tick(); push = '0;
    dump_req = 1'b1; exp_all(1, 0, 0, 1); tick(); dump_req = 1'b0;
    tick();
    reset = 1'b1; #1;
    chk("midreset_valid", 32'(if0.valid_out), 32'd0);
    chk("midreset_busy", 32'(if0.busy), 32'd0);
    chk("midreset_counter_out", 32'(if2.counter_out), 32'd0);
    chk("midreset_idx_out", 32'(if1.idx_out), 32'd0);
    tick(); tick(); reset = 1'b0;
    repeat (6) tick();

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q2_drained", 32'(q2.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asr, n_fail);
    $finish;
  end
endmodule
